// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the load and store FU ports.
// It accepts one request at a time, arbitrates round-robin between the load
// and store ports, and services the request against a local word-addressed
// SRAM after a fixed latency. The winning port gets a one-cycle ack; loads
// also return right-justified, zero-filled read data.
//
// Ports:
//   clock          - single clock, rising edge
//   reset          - asynchronous active-high; clears state and the SRAM
//   ld_req         - load request, held high until ld_ack
//   ld_packet      - load address/size (data and command fields ignored)
//   st_req         - store request, held high until st_ack
//   st_packet      - store address/size/data (command field ignored)
//   ld_ack         - one-cycle pulse, load complete
//   st_ack         - one-cycle pulse, store complete
//   Dmem2proc_data - load data, valid only while ld_ack is high, else 0
//   mem_err        - pulses with the ack of a faulting request

package dmem_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        MEM_SIZE         size;
        logic [XLEN-1:0] proc2Dmem_data;
        logic [1:0]      proc2Dmem_command;
    } FU_MEM_PACKET;
endpackage

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ld_req,
    input  FU_MEM_PACKET    ld_packet,
    input  logic            st_req,
    input  FU_MEM_PACKET    st_packet,
    output logic            ld_ack,
    output logic            st_ack,
    output logic [XLEN-1:0] Dmem2proc_data,
    output logic            mem_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LAT_INIT = CW'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state_r;
    logic            prio_r;      // 0: load port wins a tie, 1: store port wins
    logic [CW-1:0]   lat_cnt_r;
    FU_MEM_PACKET    pkt_r;
    logic            port_r;      // 0: load, 1: store
    logic            ld_ack_r;
    logic            st_ack_r;
    logic [XLEN-1:0] data_r;
    logic            err_r;
    logic [31:0]     mem_r [DEPTH];

    logic            grant_st_s;
    FU_MEM_PACKET    sel_pkt_s;
    logic            misalign_s;
    logic            out_of_range_s;
    logic            fault_s;
    logic [AW-1:0]   word_idx_s;
    logic [1:0]      lane_s;
    logic [31:0]     rd_word_s;
    logic            finish_s;
    logic            unused_cmd_s;

    // Right-justify the addressed lanes of a word and zero-fill above them.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input MEM_SIZE     size,
                                                 input logic [1:0]  lane);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (size)
            BYTE:    return {24'h000000, shifted[7:0]};
            HALF:    return {16'h0000, shifted[15:0]};
            WORD:    return word;
            default: return 32'h00000000;
        endcase
    endfunction

    // Merge store data into the addressed lanes, preserving the other bytes.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input MEM_SIZE     size,
                                                input logic [1:0]  lane);
        logic [3:0]  be;
        logic [31:0] shifted;
        logic [31:0] merged;
        case (size)
            BYTE:    be = 4'b0001 << lane;
            HALF:    be = 4'b0011 << lane;
            WORD:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        shifted = wdata << {lane, 3'b000};
        merged  = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = shifted[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Arbitration: a tie goes to the port named by prio_r.
    always_comb begin
        grant_st_s = 1'b0;
        if (ld_req && st_req) begin
            grant_st_s = prio_r;
        end else if (st_req) begin
            grant_st_s = 1'b1;
        end else begin
            grant_st_s = 1'b0;
        end
        sel_pkt_s = grant_st_s ? st_packet : ld_packet;
    end

    // Fault detection on the latched request; DOUBLE is never supported.
    always_comb begin
        misalign_s = 1'b0;
        case (pkt_r.size)
            BYTE:    misalign_s = 1'b0;
            HALF:    misalign_s = pkt_r.addr[0];
            WORD:    misalign_s = (pkt_r.addr[1:0] != 2'b00);
            default: misalign_s = 1'b1;
        endcase
    end

    assign out_of_range_s = |pkt_r.addr[XLEN-1:AW+2];
    assign fault_s        = misalign_s | out_of_range_s;
    assign word_idx_s     = pkt_r.addr[AW+1:2];
    assign lane_s         = pkt_r.addr[1:0];
    assign rd_word_s      = mem_r[word_idx_s];
    assign finish_s       = (state_r == S_BUSY) && (lat_cnt_r == '0);
    assign unused_cmd_s   = ^pkt_r.proc2Dmem_command;

    // Request FSM, arbitration pointer and registered response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            prio_r    <= 1'b0;
            lat_cnt_r <= '0;
            pkt_r     <= '0;
            port_r    <= 1'b0;
            ld_ack_r  <= 1'b0;
            st_ack_r  <= 1'b0;
            data_r    <= '0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (ld_req || st_req) begin
                        state_r   <= S_BUSY;
                        lat_cnt_r <= LAT_INIT;
                        pkt_r     <= sel_pkt_s;
                        port_r    <= grant_st_s;
                        if (ld_req && st_req) begin
                            prio_r <= ~grant_st_s;
                        end else begin
                            prio_r <= prio_r;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (lat_cnt_r == '0) begin
                        state_r  <= S_RESP;
                        ld_ack_r <= ~port_r;
                        st_ack_r <= port_r;
                        err_r    <= fault_s;
                        if (!port_r && !fault_s) begin
                            data_r <= load_extract(rd_word_s, pkt_r.size, lane_s);
                        end else begin
                            data_r <= '0;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r - CW'(1);
                    end
                end
                S_RESP: begin
                    // Requests are deliberately not sampled here so the
                    // acked FU has this cycle to drop its request.
                    state_r  <= S_IDLE;
                    ld_ack_r <= 1'b0;
                    st_ack_r <= 1'b0;
                    err_r    <= 1'b0;
                    data_r   <= '0;
                end
                default: begin
                    state_r  <= S_IDLE;
                    ld_ack_r <= 1'b0;
                    st_ack_r <= 1'b0;
                    err_r    <= 1'b0;
                    data_r   <= '0;
                end
            endcase
        end
    end

    // SRAM: cleared by reset, written at the edge a non-faulting store completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h00000000;
            end
        end else if (finish_s && port_r && !fault_s) begin
            mem_r[word_idx_s] <= store_merge(rd_word_s, pkt_r.proc2Dmem_data,
                                             pkt_r.size, lane_s);
        end
    end

    assign ld_ack         = ld_ack_r;
    assign st_ack         = st_ack_r;
    assign Dmem2proc_data = data_r;
    assign mem_err        = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            ld_req = 1'b0;
    logic            st_req = 1'b0;
    FU_MEM_PACKET    ld_packet = '0;
    FU_MEM_PACKET    st_packet = '0;
    logic            ld_ack;
    logic            st_ack;
    logic [31:0]     Dmem2proc_data;
    logic            mem_err;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .ld_req         (ld_req),
        .ld_packet      (ld_packet),
        .st_req         (st_req),
        .st_packet      (st_packet),
        .ld_ack         (ld_ack),
        .st_ack         (st_ack),
        .Dmem2proc_data (Dmem2proc_data),
        .mem_err        (mem_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on one port; lat counts negedges from raising req to ack.
    task automatic txn(input bit is_st, input logic [31:0] addr, input MEM_SIZE size,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
        FU_MEM_PACKET pkt;
        @(negedge clock);
        pkt.addr = addr;
        pkt.size = size;
        pkt.proc2Dmem_data = wdata;
        pkt.proc2Dmem_command = 2'b01;
        if (is_st) begin
            st_packet = pkt;
            st_req = 1'b1;
        end else begin
            ld_packet = pkt;
            ld_req = 1'b1;
        end
        lat = 0;
        rdata = 32'hxxxxxxxx;
        err = 1'bx;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if ((is_st ? st_ack : ld_ack) === 1'b1) begin
                lat = n;
                rdata = Dmem2proc_data;
                err = mem_err;
                break;
            end
        end
        ld_req = 1'b0;
        st_req = 1'b0;
    endtask

    // Both ports raise req on the same edge; each drops on its own ack.
    task automatic pair(input logic [31:0] ld_addr, input logic [31:0] st_addr,
                        input logic [31:0] st_data, output int ld_first, output int st_first,
                        output int ld_cnt, output int st_cnt, output logic [31:0] ld_data);
        @(negedge clock);
        ld_packet = '{addr: ld_addr, size: WORD, proc2Dmem_data: 32'h0, proc2Dmem_command: 2'b00};
        st_packet = '{addr: st_addr, size: WORD, proc2Dmem_data: st_data, proc2Dmem_command: 2'b00};
        ld_req = 1'b1;
        st_req = 1'b1;
        ld_first = 0; st_first = 0; ld_cnt = 0; st_cnt = 0; ld_data = 32'hxxxxxxxx;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (ld_ack === 1'b1) begin
                ld_cnt++;
                if (ld_first == 0) ld_first = n;
                ld_data = Dmem2proc_data;
                ld_req = 1'b0;
            end
            if (st_ack === 1'b1) begin
                st_cnt++;
                if (st_first == 0) st_first = n;
                st_req = 1'b0;
            end
        end
        ld_req = 1'b0;
        st_req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          lf, sf, lc, sc;
        int          acks;

        // Asynchronous reset at start.
        #1 reset = 1'b1;
        #2;
        check("rst_ld_ack", {31'd0, ld_ack}, 32'd0);
        check("rst_st_ack", {31'd0, st_ack}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        check("rst_data", Dmem2proc_data, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        txn(1'b0, 32'h0, WORD, 32'h0, rd, er, lat);
        check("ld0_data", rd, 32'h00000000);
        check("ld0_lat", 32'(lat), 32'd3);

        // Word round trip.
        txn(1'b1, 32'h10, WORD, 32'hDEADBEEF, rd, er, lat);
        check("st10_lat", 32'(lat), 32'd3);
        check("st10_err", {31'd0, er}, 32'd0);
        check("st10_data_zero", rd, 32'h0);
        txn(1'b0, 32'h10, WORD, 32'h0, rd, er, lat);
        check("ld10_lat", 32'(lat), 32'd3);
        check("ld10_data", rd, 32'hDEADBEEF);

        // Partial store and sub-word loads.
        txn(1'b1, 32'h13, BYTE, 32'hFFFFFF5A, rd, er, lat);
        check("stb13_err", {31'd0, er}, 32'd0);
        txn(1'b0, 32'h10, WORD, 32'h0, rd, er, lat);
        check("ldw10_merged", rd, 32'h5AADBEEF);
        txn(1'b0, 32'h12, HALF, 32'h0, rd, er, lat);
        check("ldh12", rd, 32'h00005AAD);
        txn(1'b0, 32'h10, HALF, 32'h0, rd, er, lat);
        check("ldh10", rd, 32'h0000BEEF);
        txn(1'b0, 32'h11, BYTE, 32'h0, rd, er, lat);
        check("ldb11", rd, 32'h000000BE);

        // Simultaneous requests: load first, then store first.
        pair(32'h30, 32'h30, 32'h11223344, lf, sf, lc, sc, rd);
        check("pair1_ld_first", 32'(lf), 32'd3);
        check("pair1_st_first", 32'(sf), 32'd7);
        check("pair1_ld_cnt", 32'(lc), 32'd1);
        check("pair1_st_cnt", 32'(sc), 32'd1);
        check("pair1_ld_data", rd, 32'h00000000);
        pair(32'h30, 32'h30, 32'hCAFEF00D, lf, sf, lc, sc, rd);
        check("pair2_st_first", 32'(sf), 32'd3);
        check("pair2_ld_first", 32'(lf), 32'd7);
        check("pair2_ld_cnt", 32'(lc), 32'd1);
        check("pair2_st_cnt", 32'(sc), 32'd1);
        check("pair2_ld_data", rd, 32'hCAFEF00D);

        // Faults.
        txn(1'b1, 32'h20, WORD, 32'h12345678, rd, er, lat);
        check("st20_err", {31'd0, er}, 32'd0);
        txn(1'b0, 32'h21, HALF, 32'h0, rd, er, lat);
        check("ldh21_lat", 32'(lat), 32'd3);
        check("ldh21_err", {31'd0, er}, 32'd1);
        check("ldh21_data", rd, 32'h0);
        txn(1'b1, 32'h400, WORD, 32'hFFFFFFFF, rd, er, lat);
        check("st400_lat", 32'(lat), 32'd3);
        check("st400_err", {31'd0, er}, 32'd1);
        txn(1'b0, 32'h0, WORD, 32'h0, rd, er, lat);
        check("ld0_unchanged", rd, 32'h00000000);
        check("ld0_err", {31'd0, er}, 32'd0);
        txn(1'b1, 32'h22, WORD, 32'hAAAAAAAA, rd, er, lat);
        check("st22_err", {31'd0, er}, 32'd1);
        txn(1'b0, 32'h20, WORD, 32'h0, rd, er, lat);
        check("ld20_unchanged", rd, 32'h12345678);
        txn(1'b0, 32'h20, DOUBLE, 32'h0, rd, er, lat);
        check("lddbl_err", {31'd0, er}, 32'd1);
        check("lddbl_data", rd, 32'h0);

        // Asynchronous reset mid-cycle while an ack is being presented.
        @(negedge clock);
        ld_packet = '{addr: 32'h10, size: WORD, proc2Dmem_data: 32'h0, proc2Dmem_command: 2'b00};
        ld_req = 1'b1;
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (ld_ack === 1'b1) begin
                lat = n;
                break;
            end
        end
        check("pre_rst_lat", 32'(lat), 32'd3);
        check("pre_rst_data", Dmem2proc_data, 32'h5AADBEEF);
        #2 reset = 1'b1;
        ld_req = 1'b0;
        #1;
        check("midrst_ld_ack", {31'd0, ld_ack}, 32'd0);
        check("midrst_data", Dmem2proc_data, 32'h0);
        check("midrst_err", {31'd0, mem_err}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        txn(1'b0, 32'h0, WORD, 32'h0, rd, er, lat);
        check("post_rst_ld0", rd, 32'h0);
        check("post_rst_ld0_lat", 32'(lat), 32'd3);
        txn(1'b0, 32'h10, WORD, 32'h0, rd, er, lat);
        check("post_rst_ld10_cleared", rd, 32'h0);

        // Abort a store in BUSY with reset.
        @(negedge clock);
        st_packet = '{addr: 32'h40, size: WORD, proc2Dmem_data: 32'h99999999, proc2Dmem_command: 2'b00};
        st_req = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        st_req = 1'b0;
        #1;
        check("abort_st_ack_now", {31'd0, st_ack}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            if (st_ack === 1'b1) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        txn(1'b0, 32'h40, WORD, 32'h0, rd, er, lat);
        check("abort_ld40", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
